// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: redirect inputs, BTB training inputs and fetch outputs.
// master: pipeline/testbench side (drives redirects and updates, reads fetch PC).
// slave:  pc_fetch side (reads redirects and updates, drives fetch PC and prediction).
interface pc_fetch_if;
   logic        stall;
   logic        fail_predictD;
   logic [12:0] nextpcD;
   logic        fail_predictE;
   logic [12:0] nextpcE;
   logic        upd_en;
   logic [12:0] upd_pc;
   logic        upd_taken;
   logic [12:0] upd_target;
   logic [12:0] pcF;
   logic        pred_takenF;
   logic [12:0] pred_targetF;

   modport master (
      output stall, fail_predictD, nextpcD, fail_predictE, nextpcE,
             upd_en, upd_pc, upd_taken, upd_target,
      input  pcF, pred_takenF, pred_targetF
   );

   modport slave (
      input  stall, fail_predictD, nextpcD, fail_predictE, nextpcE,
             upd_en, upd_pc, upd_taken, upd_target,
      output pcF, pred_takenF, pred_targetF
   );
endinterface

// File: rtl/pc_fetch.sv
// Fetch PC generator with a direct-mapped BTB and 2-bit saturating direction counters.
// Latency: pcF is registered (next-PC choice visible one cycle later); BTB lookup is combinational on pcF.
// Backpressure: stall holds pcF and masks redirects; BTB training proceeds regardless of stall.
// Ports: CLK, NRST (synchronous, active-low); bus (slave) carries stall, D/E redirects,
//        EX update (upd_en/upd_pc/upd_taken/upd_target) and outputs pcF/pred_takenF/pred_targetF.
module pc_fetch #(
   parameter logic [12:0] START_PC = 13'd0,
   parameter int          IDX_W    = 4
) (
   input  logic         CLK,
   input  logic         NRST,
   pc_fetch_if.slave    bus
);
   localparam int DEPTH = 1 << IDX_W;
   localparam int TAG_W = 13 - IDX_W;

   logic             btb_valid  [DEPTH];
   logic [TAG_W-1:0] btb_tag    [DEPTH];
   logic [12:0]      btb_target [DEPTH];
   logic [1:0]       btb_ctr    [DEPTH];

   logic [12:0]      pc_q;
   logic [12:0]      pc_next;

   // Lookup side
   logic [IDX_W-1:0] rd_idx;
   logic             rd_hit;
   logic             pred_taken;
   logic [12:0]      pred_target;

   assign rd_idx      = pc_q[IDX_W-1:0];
   assign rd_hit      = btb_valid[rd_idx] && (btb_tag[rd_idx] == pc_q[12:IDX_W]);
   assign pred_taken  = rd_hit && btb_ctr[rd_idx][1];
   assign pred_target = pred_taken ? btb_target[rd_idx] : pc_q + 13'd1;

   assign bus.pcF          = pc_q;
   assign bus.pred_takenF  = pred_taken;
   assign bus.pred_targetF = pred_target;

   // Update side
   logic [IDX_W-1:0] wr_idx;
   logic             wr_hit;
   logic [1:0]       ctr_old;
   logic [1:0]       ctr_inc;
   logic [1:0]       ctr_dec;

   assign wr_idx  = bus.upd_pc[IDX_W-1:0];
   assign wr_hit  = btb_valid[wr_idx] && (btb_tag[wr_idx] == bus.upd_pc[12:IDX_W]);
   assign ctr_old = btb_ctr[wr_idx];
   assign ctr_inc = (ctr_old == 2'b11) ? 2'b11 : ctr_old + 2'b01;
   assign ctr_dec = (ctr_old == 2'b00) ? 2'b00 : ctr_old - 2'b01;

   // Next-PC selection; E outranks D because it is the older instruction.
   always_comb begin
      pc_next = pred_target;
      if (bus.stall)
         pc_next = pc_q;
      else if (bus.fail_predictE)
         pc_next = bus.nextpcE;
      else if (bus.fail_predictD)
         pc_next = bus.nextpcD;
   end

   always_ff @(posedge CLK) begin
      if (!NRST)
         pc_q <= START_PC;
      else
         pc_q <= pc_next;
   end

   // Valid and counter state carry the reset; tag/target are don't-care while invalid.
   always_ff @(posedge CLK) begin
      if (!NRST) begin
         for (int i = 0; i < DEPTH; i++) begin
            btb_valid[i] <= 1'b0;
            btb_ctr[i]   <= 2'b01;
         end
      end else if (bus.upd_en) begin
         if (wr_hit) begin
            btb_ctr[wr_idx] <= bus.upd_taken ? ctr_inc : ctr_dec;
         end else if (bus.upd_taken) begin
            btb_valid[wr_idx] <= 1'b1;
            btb_ctr[wr_idx]   <= 2'b10;
         end
      end
   end

   // Any taken outcome writes tag and target: on a hit the tag is unchanged,
   // on a miss it is an allocation.
   always_ff @(posedge CLK) begin
      if (NRST && bus.upd_en && bus.upd_taken) begin
         btb_tag[wr_idx]    <= bus.upd_pc[12:IDX_W];
         btb_target[wr_idx] <= bus.upd_target;
      end
   end
endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;
   localparam logic [12:0] START = 13'd0;

   logic CLK = 1'b0;
   logic NRST;
   always #5 CLK = ~CLK;

   pc_fetch_if bus ();

   pc_fetch #(.START_PC(START), .IDX_W(4)) dut (
      .CLK  (CLK),
      .NRST (NRST),
      .bus  (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   // Behavioural model: a 16-slot table keyed by pc mod 16 that remembers the
   // full PC of its owner; a hit is simply "the stored PC equals this PC".
   bit          m_on = 0;
   logic [12:0] m_pc;
   bit          m_val [16];
   logic [12:0] m_own [16];
   logic [12:0] m_tgt [16];
   int          m_ctr [16];

   function automatic void m_predict(input logic [12:0] pc, output bit tk, output logic [12:0] nx);
      int e;
      e  = pc % 16;
      tk = m_val[e] && (m_own[e] == pc) && (m_ctr[e] >= 2);
      nx = tk ? m_tgt[e] : 13'((pc + 1) % 8192);
   endfunction

   always @(posedge CLK) begin
      bit          tk;
      logic [12:0] nx;
      int          e;
      if (!NRST) begin
         m_on = 1;
         m_pc = START;
         for (int i = 0; i < 16; i++) begin
            m_val[i] = 0;
            m_ctr[i] = 1;
         end
      end else if (m_on) begin
         m_predict(m_pc, tk, nx);
         if (bus.stall)              nx = m_pc;
         else if (bus.fail_predictE) nx = bus.nextpcE;
         else if (bus.fail_predictD) nx = bus.nextpcD;
         if (bus.upd_en) begin
            e = bus.upd_pc % 16;
            if (m_val[e] && m_own[e] == bus.upd_pc) begin
               if (bus.upd_taken) begin
                  m_ctr[e] = (m_ctr[e] < 3) ? m_ctr[e] + 1 : 3;
                  m_tgt[e] = bus.upd_target;
               end else begin
                  m_ctr[e] = (m_ctr[e] > 0) ? m_ctr[e] - 1 : 0;
               end
            end else if (bus.upd_taken) begin
               m_val[e] = 1;
               m_own[e] = bus.upd_pc;
               m_tgt[e] = bus.upd_target;
               m_ctr[e] = 2;
            end
         end
         m_pc = nx;
      end
   end

   always @(negedge CLK) begin
      bit          tk;
      logic [12:0] nx;
      if (m_on) begin
         m_predict(m_pc, tk, nx);
         check("model_pcF",          bus.pcF,                 m_pc);
         check("model_pred_takenF",  {12'd0, bus.pred_takenF}, {12'd0, tk});
         check("model_pred_targetF", bus.pred_targetF,        nx);
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      bus.stall = 0; bus.fail_predictD = 0; bus.nextpcD = 0;
      bus.fail_predictE = 0; bus.nextpcE = 0;
      bus.upd_en = 0; bus.upd_pc = 0; bus.upd_taken = 0; bus.upd_target = 0;
   endtask

   task automatic redirect(input logic [12:0] pc);
      idle();
      bus.fail_predictE = 1;
      bus.nextpcE = pc;
      cyc();
      bus.fail_predictE = 0;
   endtask

   task automatic train(input logic [12:0] pc, input logic tk, input logic [12:0] tgt);
      idle();
      bus.upd_en = 1; bus.upd_pc = pc; bus.upd_taken = tk; bus.upd_target = tgt;
      cyc();
      bus.upd_en = 0;
   endtask

   initial begin
      NRST = 0;
      idle();
      // Reset and sequential fetch
      cyc(); cyc();
      check("rst_pcF", bus.pcF, 13'd0);
      check("rst_pred_taken", {12'd0, bus.pred_takenF}, 13'd0);
      check("rst_pred_target", bus.pred_targetF, 13'd1);
      NRST = 1;
      for (int i = 1; i <= 3; i++) begin
         cyc();
         check("seq_pcF", bus.pcF, 13'(i));
         check("seq_pred_taken", {12'd0, bus.pred_takenF}, 13'd0);
      end

      // Wrap and stall
      redirect(13'd8190);
      check("wrap_8190", bus.pcF, 13'd8190);
      cyc(); check("wrap_8191", bus.pcF, 13'd8191);
      cyc(); check("wrap_0", bus.pcF, 13'd0);
      bus.stall = 1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("stall_hold", bus.pcF, 13'd0);
      end
      bus.stall = 0;
      cyc(); check("stall_release", bus.pcF, 13'd1);

      // Allocate and predict
      train(13'h020, 1, 13'h100);
      redirect(13'h020);
      check("alloc_pred_taken", {12'd0, bus.pred_takenF}, 13'd1);
      check("alloc_pred_target", bus.pred_targetF, 13'h100);
      cyc(); check("alloc_follow", bus.pcF, 13'h100);

      // Hysteresis: 10 -> 11 -> 10 (still taken) -> 01 (not taken)
      train(13'h020, 1, 13'h100);
      train(13'h020, 0, 13'h000);
      redirect(13'h020);
      check("hyst_weak_taken", {12'd0, bus.pred_takenF}, 13'd1);
      train(13'h020, 0, 13'h000);
      redirect(13'h020);
      check("hyst_weak_nt", {12'd0, bus.pred_takenF}, 13'd0);
      check("hyst_weak_nt_tgt", bus.pred_targetF, 13'h021);
      // Two more not-taken saturate at 00; one taken then reaches only 01.
      train(13'h020, 0, 13'h000);
      train(13'h020, 0, 13'h000);
      train(13'h020, 1, 13'h100);
      redirect(13'h020);
      check("sat_low_then_inc", {12'd0, bus.pred_takenF}, 13'd0);
      train(13'h020, 1, 13'h100);
      redirect(13'h020);
      check("sat_low_two_inc", {12'd0, bus.pred_takenF}, 13'd1);

      // Priority: E beats D, stall beats both
      idle();
      bus.fail_predictD = 1; bus.nextpcD = 13'h050;
      bus.fail_predictE = 1; bus.nextpcE = 13'h070;
      cyc(); check("prio_e_over_d", bus.pcF, 13'h070);
      bus.stall = 1;
      cyc(); check("prio_stall", bus.pcF, 13'h070);
      idle();

      // Same-cycle update/lookup, then aliasing (0x030 and 0x040 share index 0)
      redirect(13'h030);
      bus.upd_en = 1; bus.upd_pc = 13'h030; bus.upd_taken = 1; bus.upd_target = 13'h200;
      #1;
      check("same_cycle_old", {12'd0, bus.pred_takenF}, 13'd0);
      cyc(); check("same_cycle_next", bus.pcF, 13'h031);
      redirect(13'h030);
      check("revisit_taken", {12'd0, bus.pred_takenF}, 13'd1);
      check("revisit_target", bus.pred_targetF, 13'h200);
      cyc(); check("revisit_follow", bus.pcF, 13'h200);
      train(13'h040, 1, 13'h300);
      redirect(13'h030);
      check("alias_evicted", {12'd0, bus.pred_takenF}, 13'd0);
      check("alias_evicted_tgt", bus.pred_targetF, 13'h031);

      // Reset mid-operation overrides stall, redirect and update
      idle();
      NRST = 0;
      bus.stall = 1;
      bus.fail_predictE = 1; bus.nextpcE = 13'h777;
      bus.upd_en = 1; bus.upd_pc = 13'h050; bus.upd_taken = 1; bus.upd_target = 13'h123;
      cyc();
      check("midrst_pcF", bus.pcF, START);
      check("midrst_pred_target", bus.pred_targetF, 13'd1);
      idle();
      NRST = 1;
      redirect(13'h040);
      check("midrst_cleared", {12'd0, bus.pred_takenF}, 13'd0);
      redirect(13'h050);
      check("midrst_upd_dropped", {12'd0, bus.pred_takenF}, 13'd0);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pc_fetch.md
# pc_fetch

Fetch-stage PC generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating predictors. It owns the fetch PC `pcF`, which drives the combinational instruction-memory read and feeds the F/D pipeline register. Each cycle it selects the next PC from four sources, in priority order:

- reset,
- stall,
- misprediction redirect from D or E,
- BTB prediction.

The EX stage trains the BTB with resolved control-flow outcomes.

## Interface
- `START_PC`, default 13'd0: PC value loaded at reset.
- `IDX_W`, default 4: BTB index width; the BTB has 2^IDX_W entries.
- `CLK`  in  1  clock.
- `NRST`  in  1  reset, synchronous, active-low.
- `stall`  in  1  hazard stall; hold `pcF`.
- `fail_predictD`  in  1  misprediction detected in D; redirect to `nextpcD`.
- `nextpcD`  in  13  correct PC from D.
- `fail_predictE`  in  1  misprediction detected in E; redirect to `nextpcE`.
- `nextpcE`  in  13  correct PC from E.
- `upd_en`  in  1  EX resolved a branch or jump this cycle.
- `upd_pc`  in  13  PC of the resolved instruction.
- `upd_taken`  in  1  actual direction.
- `upd_target`  in  13  actual taken target.
- `pcF`  out  13  current fetch PC, in word units; drives the instruction-memory address.
- `pred_takenF`  out  1  BTB predicts `pcF` as taken.
- `pred_targetF`  out  13  predicted next PC: the BTB target if `pred_takenF`, else `pcF`+1.

## Operation
- PC arithmetic is in words and modulo 2^13, so 8191+1 = 0.
- BTB entry fields: `valid`, `tag` (`pc[12:IDX_W]`), `target` (13 bits), `ctr` (2 bits).
- BTB index is `pc[IDX_W-1:0]`.
- Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
- Lookup is combinational on `pcF`.
  - hit = `valid` && `tag` == `pcF[12:IDX_W]`.
  - `pred_takenF` = hit && `ctr[1]`.
- Next-PC selection, first match wins:
  1. `!NRST`: `START_PC`.
  2. `stall`: hold `pcF`. Redirects are ignored; D and E keep them asserted while stalled.
  3. `fail_predictE`: `nextpcE`. The older instruction has priority over D.
  4. `fail_predictD`: `nextpcD`.
  5. Otherwise: `pred_targetF`.
- BTB update happens on every clock edge where `upd_en` is high and NRST is high. It is independent of `stall` and redirects.
  - **Tag hit, taken:** `ctr` saturating +1 (11 stays 11); `target` <= `upd_target`.
  - **Tag hit, not taken:** `ctr` saturating -1 (00 stays 00); `target` unchanged.
  - **Miss, taken:** allocate or overwrite the entry: `valid`=1, `tag`, `target` <= `upd_target`, `ctr`=10.
  - **Miss, not taken:** no change.
- Reset, while NRST is low at a clock edge:
  - all `valid` cleared and all `ctr` set to 01;
  - `tag` and `target` are don't-care;
  - any in-flight update is discarded.

## Timing
- `pcF` is registered. The next-PC decision made in cycle N is visible in cycle N+1.
- Redirect penalty is fixed by the downstream registers, not by this block: `pcF` = `nextpcX` exactly one cycle after `fail_predictX`.
- Update-to-lookup latency is 1 cycle. A lookup in the same cycle as a write to the same entry sees the old contents.
- Output values during and after reset:

  | Output | Value |
  |---|---|
  | `pcF` | `START_PC` |
  | `pred_takenF` | 0 (all entries invalid) |
  | `pred_targetF` | `START_PC`+1 |

- Reset mid-operation: takes effect at the first edge with NRST low, overriding stall, redirect and update.
- Aliasing: two PCs with the same index but different tags evict each other. There is no associativity.

## Test plan
- **Reset and sequential fetch:** hold NRST low for 2 cycles with `START_PC`=0, then release with no stimulus.
  - `pcF` = 0, 1, 2, …
  - `pred_takenF` = 0 throughout.
- **Wrap and stall:** redirect via `fail_predictE` with `nextpcE`=8190, then run.
  - `pcF` = 8190, 8191, 0.
  - With `stall` high for 3 cycles at `pcF`=0, `pcF` stays 0 for those cycles, then advances to 1.
- **Allocate and predict:** `upd_en`=1, `upd_pc`=0x020, `upd_taken`=1, `upd_target`=0x100, then redirect to 0x020.
  - At `pcF`=0x020: `pred_takenF`=1.
  - Next cycle: `pcF`=0x100.
- **Hysteresis:** on that entry, apply taken ×1 (`ctr`→11), then not-taken ×1 (→10); `pred_takenF` is still 1.
  - A second not-taken (→01) gives `pred_takenF`=0 at 0x020.
  - Two further not-taken updates saturate `ctr` at 00.
- **Priority:** assert `fail_predictD` (`nextpcD`=0x050) and `fail_predictE` (`nextpcE`=0x070) in the same cycle.
  - `pcF`=0x070 next cycle.
  - The same stimulus with `stall`=1 leaves `pcF` unchanged.
- **Same-cycle update/lookup and aliasing:** update `upd_pc`=`pcF`=0x030 (taken, target 0x200) in the same cycle the lookup occurs.
  - That cycle: `pred_takenF`=0.
  - On the next visit to 0x030: `pred_takenF`=1.
  - Then allocate 0x040 (same index with `IDX_W`=4): 0x030 now misses.
